// File: rtl/drivetrain_integrator.sv
// Drivetrain model: converts RPM and gear into a slew-limited velocity, a per-tick
// displacement and a saturating race position, with clutch dead-time and finish detection.
module drivetrain_integrator #(
  parameter int RPM_W = 14,
  parameter int GEARS = 4,
  localparam int GEAR_W = (GEARS > 1) ? $clog2(GEARS) : 1,
  parameter int RATIO_W = 8,
  parameter logic [GEARS*RATIO_W-1:0] RATIOS = {8'd5, 8'd3, 8'd2, 8'd1},
  parameter int SHIFT = 9,
  parameter int DPOS_W = 7,
  parameter int POS_W = 16,
  parameter int ACCEL = 64,
  parameter int SHIFT_DELAY = 10,
  parameter int TRACK_LEN = 1000
) (
  input  logic                     clk100Hz,
  input  logic                     rst,
  input  logic                     reset_status,
  input  logic                     start,
  input  logic [RPM_W-1:0]         rpm,
  input  logic [GEAR_W-1:0]        gear,
  output logic [DPOS_W-1:0]        d_position,
  output logic [POS_W-1:0]         position,
  output logic [RPM_W+RATIO_W-1:0] velocity,
  output logic                     shifting,
  output logic                     finished
);

  localparam int VEL_W = RPM_W + RATIO_W;
  localparam int CNT_W = (SHIFT_DELAY > 1) ? $clog2(SHIFT_DELAY) : 1;
  localparam logic [VEL_W:0]     ACCEL_X    = (VEL_W+1)'(ACCEL);
  localparam logic [VEL_W-1:0]   DP_MAX     = VEL_W'((2 ** DPOS_W) - 1);
  localparam logic [POS_W-1:0]   TRACK_END  = POS_W'(TRACK_LEN);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'((SHIFT_DELAY > 0) ? (SHIFT_DELAY - 1) : 0);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_SHIFTING = 2'd2;
  localparam logic [1:0] ST_FINISHED = 2'd3;

  logic [1:0]        state_r, state_s;
  logic [GEAR_W-1:0] gear_q_r, gear_q_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [VEL_W-1:0]  velocity_r, velocity_s;
  logic [DPOS_W-1:0] d_position_r, d_position_s;
  logic [POS_W-1:0]  position_r, position_s;
  logic              shifting_r, finished_r;

  logic [RATIO_W-1:0] ratio_s;
  logic [VEL_W-1:0]   target_s, nv_s, vshift_s;
  logic [VEL_W:0]     up_lim_s, dn_lim_s;
  logic [DPOS_W-1:0]  dp_s;
  logic [POS_W-1:0]   pos_run_s, pos_hold_s;
  logic               gear_change_s;

  // Gears outside the table select a zero ratio, which makes the target speed 0
  function automatic logic [RATIO_W-1:0] ratio_of(input logic [GEAR_W-1:0] g);
    logic [RATIO_W-1:0] r;
    r = '0;
    for (int i = 0; i < GEARS; i++) begin
      if (g == GEAR_W'(i)) begin
        r = RATIOS[i*RATIO_W +: RATIO_W];
      end
    end
    return r;
  endfunction

  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] p, input logic [DPOS_W-1:0] d);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + {{(POS_W+1-DPOS_W){1'b0}}, d};
    if (sum >= {1'b0, TRACK_END}) begin
      return TRACK_END;
    end else begin
      return sum[POS_W-1:0];
    end
  endfunction

  // Target velocity, slew limiting and saturated displacement for this tick
  always_comb begin
    ratio_s  = ratio_of(gear);
    target_s = {{RPM_W{1'b0}}, ratio_s} * {{RATIO_W{1'b0}}, rpm};
    up_lim_s = {1'b0, velocity_r} + ACCEL_X;
    dn_lim_s = {1'b0, target_s} + ACCEL_X;
    if ({1'b0, target_s} > up_lim_s) begin
      nv_s = up_lim_s[VEL_W-1:0];
    end else if ({1'b0, velocity_r} > dn_lim_s) begin
      nv_s = velocity_r - ACCEL_X[VEL_W-1:0];
    end else begin
      nv_s = target_s;
    end
    vshift_s = nv_s >> SHIFT;
    if (vshift_s > DP_MAX) begin
      dp_s = {DPOS_W{1'b1}};
    end else begin
      dp_s = vshift_s[DPOS_W-1:0];
    end
    pos_run_s     = sat_add(position_r, dp_s);
    pos_hold_s    = sat_add(position_r, d_position_r);
    gear_change_s = (gear != gear_q_r);
  end

  // Race state machine; reaching the track end wins over any gear change
  always_comb begin
    state_s      = state_r;
    gear_q_s     = gear_q_r;
    cnt_s        = cnt_r;
    velocity_s   = velocity_r;
    d_position_s = d_position_r;
    position_s   = position_r;
    case (state_r)
      ST_IDLE: begin
        velocity_s   = '0;
        d_position_s = '0;
        position_s   = '0;
        if (start) begin
          state_s  = ST_RUN;
          gear_q_s = gear;
        end else begin
          gear_q_s = gear_q_r;
        end
      end
      ST_RUN: begin
        gear_q_s = gear;
        if (gear_change_s) begin
          position_s = pos_hold_s;
          if (pos_hold_s == TRACK_END) begin
            state_s = ST_FINISHED;
          end else if (SHIFT_DELAY > 0) begin
            state_s = ST_SHIFTING;
            cnt_s   = CNT_RELOAD;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          position_s = pos_run_s;
          if (pos_run_s == TRACK_END) begin
            state_s = ST_FINISHED;
          end else begin
            velocity_s   = nv_s;
            d_position_s = dp_s;
          end
        end
      end
      ST_SHIFTING: begin
        gear_q_s   = gear;
        position_s = pos_hold_s;
        if (pos_hold_s == TRACK_END) begin
          state_s = ST_FINISHED;
        end else if (gear_change_s) begin
          cnt_s = CNT_RELOAD;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_RUN;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FINISHED: begin
        state_s = ST_FINISHED;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (state_s == ST_FINISHED) begin
      velocity_s   = '0;
      d_position_s = '0;
      position_s   = TRACK_END;
      cnt_s        = '0;
    end else begin
      cnt_s = cnt_s;
    end
  end

  // State and output registers with synchronous race restart
  always_ff @(posedge clk100Hz) begin
    if (rst || reset_status) begin
      state_r      <= ST_IDLE;
      gear_q_r     <= '0;
      cnt_r        <= '0;
      velocity_r   <= '0;
      d_position_r <= '0;
      position_r   <= '0;
      shifting_r   <= 1'b0;
      finished_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      gear_q_r     <= gear_q_s;
      cnt_r        <= cnt_s;
      velocity_r   <= velocity_s;
      d_position_r <= d_position_s;
      position_r   <= position_s;
      shifting_r   <= (state_s == ST_SHIFTING);
      finished_r   <= (state_s == ST_FINISHED);
    end
  end

  assign velocity   = velocity_r;
  assign d_position = d_position_r;
  assign position   = position_r;
  assign shifting   = shifting_r;
  assign finished   = finished_r;

endmodule

// File: tb/tb_drivetrain_integrator.sv
// Bench for drivetrain_integrator: three parameterisations driven in lockstep and
// checked every tick against a behavioural race model, plus directed literal checks.
module tb_drivetrain_integrator;

  localparam int N = 3;

  logic       clk100Hz;
  logic       rst, reset_status, start;
  logic [13:0] rpm;
  logic [1:0]  gear;

  logic [6:0]  o_dp    [N];
  logic [15:0] o_pos   [N];
  logic [21:0] o_vel   [N];
  logic        o_shift [N];
  logic        o_fin   [N];

  // instance 0: defaults; 1: three gears; 2: fast accel, no clutch delay, long track
  int p_gears [N]    = '{4, 3, 4};
  int p_ratio [N][4] = '{'{1, 2, 3, 5}, '{1, 2, 3, 0}, '{1, 2, 3, 5}};
  int p_accel [N]    = '{64, 64, 4096};
  int p_delay [N]    = '{10, 10, 0};
  int p_len   [N]    = '{1000, 1000, 60000};

  longint m_vel [N];
  longint m_dp  [N];
  longint m_pos [N];
  int     m_left [N];
  int     m_gq  [N];
  bit     m_run [N];
  bit     m_done [N];

  int checks = 0;
  int failures = 0;

  drivetrain_integrator u_a (
    .clk100Hz(clk100Hz), .rst(rst), .reset_status(reset_status), .start(start),
    .rpm(rpm), .gear(gear), .d_position(o_dp[0]), .position(o_pos[0]),
    .velocity(o_vel[0]), .shifting(o_shift[0]), .finished(o_fin[0]));

  drivetrain_integrator #(.GEARS(3), .RATIOS({8'd3, 8'd2, 8'd1})) u_b (
    .clk100Hz(clk100Hz), .rst(rst), .reset_status(reset_status), .start(start),
    .rpm(rpm), .gear(gear), .d_position(o_dp[1]), .position(o_pos[1]),
    .velocity(o_vel[1]), .shifting(o_shift[1]), .finished(o_fin[1]));

  drivetrain_integrator #(.ACCEL(4096), .SHIFT_DELAY(0), .TRACK_LEN(60000)) u_c (
    .clk100Hz(clk100Hz), .rst(rst), .reset_status(reset_status), .start(start),
    .rpm(rpm), .gear(gear), .d_position(o_dp[2]), .position(o_pos[2]),
    .velocity(o_vel[2]), .shifting(o_shift[2]), .finished(o_fin[2]));

  initial begin
    clk100Hz = 1'b0;
    forever #5 clk100Hz = ~clk100Hz;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Race rules: clutch time is a count of remaining disengaged ticks
  task automatic model_step();
    longint tgt, nv, d, np;
    bit change;
    for (int i = 0; i < N; i++) begin
      if (rst || reset_status) begin
        m_vel[i] = 0; m_dp[i] = 0; m_pos[i] = 0; m_left[i] = 0;
        m_gq[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
      end else if (m_done[i]) begin
        m_done[i] = 1'b1;
      end else if (!m_run[i]) begin
        if (start) begin
          m_run[i] = 1'b1;
          m_gq[i] = int'(gear);
        end
      end else begin
        change = (int'(gear) != m_gq[i]);
        m_gq[i] = int'(gear);
        if (m_left[i] > 0 || change) begin
          np = m_pos[i] + m_dp[i];
          if (np >= p_len[i]) begin
            m_done[i] = 1'b1;
          end else begin
            m_pos[i] = np;
            m_left[i] = change ? p_delay[i] : m_left[i] - 1;
          end
        end else begin
          tgt = (int'(gear) < p_gears[i]) ? longint'(p_ratio[i][gear]) * longint'(rpm) : 0;
          if (tgt > m_vel[i] + p_accel[i]) nv = m_vel[i] + p_accel[i];
          else if (m_vel[i] > tgt + p_accel[i]) nv = m_vel[i] - p_accel[i];
          else nv = tgt;
          d = nv / 512;
          if (d > 127) d = 127;
          np = m_pos[i] + d;
          if (np >= p_len[i]) begin
            m_done[i] = 1'b1;
          end else begin
            m_vel[i] = nv; m_dp[i] = d; m_pos[i] = np;
          end
        end
        if (m_done[i]) begin
          m_vel[i] = 0; m_dp[i] = 0; m_pos[i] = p_len[i]; m_left[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_vel[%0d]", i), longint'(o_vel[i]), m_vel[i]);
      chk($sformatf("model_dpos[%0d]", i), longint'(o_dp[i]), m_dp[i]);
      chk($sformatf("model_pos[%0d]", i), longint'(o_pos[i]), m_pos[i]);
      chk($sformatf("model_shift[%0d]", i), longint'(o_shift[i]), longint'(m_left[i] > 0));
      chk($sformatf("model_fin[%0d]", i), longint'(o_fin[i]), longint'(m_done[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk100Hz);
    model_step();
    @(negedge clk100Hz);
    check_all();
  endtask

  initial begin
    int n;
    longint prev_pos, prev_dp;

    rst = 1'b1; reset_status = 1'b0; start = 1'b0; rpm = 14'd0; gear = 2'd0;
    repeat (2) tick();
    chk("reset_vel", longint'(o_vel[0]), 0);
    chk("reset_pos", longint'(o_pos[0]), 0);

    rst = 1'b0; rpm = 14'd5000; gear = 2'd2;
    repeat (20) tick();
    chk("idle_vel", longint'(o_vel[0]), 0);
    chk("idle_pos", longint'(o_pos[0]), 0);

    gear = 2'd0; rpm = 14'd1024; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_vel", longint'(o_vel[0]), 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("ramp_vel_t%0d", k), longint'(o_vel[0]), 64 * k);
      if (k == 7) chk("ramp_dp_t7", longint'(o_dp[0]), 0);
      if (k == 8) chk("ramp_dp_t8", longint'(o_dp[0]), 1);
      if (k == 16) chk("ramp_dp_t16", longint'(o_dp[0]), 2);
    end
    chk("ramp_pos_t16", longint'(o_pos[0]), 10);
    repeat (4) tick();
    chk("hold_vel", longint'(o_vel[0]), 1024);
    chk("hold_pos", longint'(o_pos[0]), 18);

    gear = 2'd1; n = 0; prev_pos = longint'(o_pos[0]);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!o_shift[0]) break;
      n++;
      chk("clutch_vel", longint'(o_vel[0]), 1024);
      chk("clutch_pos_step", longint'(o_pos[0]) - prev_pos, 2);
      prev_pos = longint'(o_pos[0]);
    end
    chk("clutch_len", n, 10);
    repeat (16) tick();
    chk("post_clutch_vel", longint'(o_vel[0]), 2048);
    chk("post_clutch_pos", longint'(o_pos[0]), 82);

    gear = 2'd0; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) gear = 2'd1;
      tick();
      if (!o_shift[0]) break;
      n++;
    end
    chk("clutch_ext_len", n, 15);

    n = 0; prev_pos = 0; prev_dp = 0;
    for (int i = 0; i < 500; i++) begin
      prev_pos = longint'(o_pos[0]);
      prev_dp = longint'(o_dp[0]);
      tick();
      if (o_fin[0]) break;
    end
    chk("fin_flag", longint'(o_fin[0]), 1);
    chk("fin_pos", longint'(o_pos[0]), 1000);
    chk("fin_dp", longint'(o_dp[0]), 0);
    chk("fin_vel", longint'(o_vel[0]), 0);
    chk("fin_crossed", longint'(prev_pos + prev_dp >= 1000), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fin_start_ignored", longint'(o_fin[0]), 1);
    chk("fin_start_pos", longint'(o_pos[0]), 1000);
    reset_status = 1'b1;
    tick();
    reset_status = 1'b0;
    chk("rstat_pos", longint'(o_pos[0]), 0);
    chk("rstat_fin", longint'(o_fin[0]), 0);
    chk("rstat_vel", longint'(o_vel[0]), 0);

    gear = 2'd3; rpm = 14'd16383; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    chk("sat_vel", longint'(o_vel[2]), 81915);
    chk("sat_dp", longint'(o_dp[2]), 127);
    chk("slow_vel", longint'(o_vel[0]), 1600);
    chk("bad_gear_vel", longint'(o_vel[1]), 0);
    rpm = 14'd0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk($sformatf("decel_vel_t%0d", k), longint'(o_vel[0]), 1600 - 64 * k);
    end

    reset_status = 1'b1;
    tick();
    reset_status = 1'b0;
    gear = 2'd2; rpm = 14'd1024; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("g3_vel", longint'(o_vel[1]), 640);
    gear = 2'd3;
    repeat (15) tick();
    chk("g3_decay", longint'(o_vel[1]), 384);
    repeat (6) tick();
    chk("g3_decay_zero", longint'(o_vel[1]), 0);

    gear = 2'd1;
    tick();
    chk("midshift_shift", longint'(o_shift[1]), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midshift_rst_shift", longint'(o_shift[1]), 0);
    chk("midshift_rst_pos", longint'(o_pos[1]), 0);
    chk("midshift_rst_dp", longint'(o_dp[1]), 0);

    for (int t = 0; t < 4000; t++) begin
      rst = ($urandom_range(0, 999) == 0);
      reset_status = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) gear = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) == 0) rpm = 14'($urandom_range(0, 16383));
        else rpm = 14'($urandom_range(0, 3000));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
